// File: rtl/johnson_pkg.sv
// Shared definitions for consumers of a WIDTH-bit Johnson (twisted-ring) counter:
// lock state encoding and width-generic code helpers. Helpers take the code
// zero-extended to MAX_W bits plus the real width, so one package serves any width.
package johnson_pkg;

  localparam int MAX_W     = 32;
  localparam int JOHNSON_W = 4;
  localparam int IDX_W     = $clog2(2 * JOHNSON_W);

  typedef enum logic [1:0] {
    S_UNLOCK = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCK   = 2'd2
  } lock_state_t;

  // Legal successor: shift left, feed back the inverted MSB.
  function automatic logic [MAX_W-1:0] johnson_succ(input logic [MAX_W-1:0] q, input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 1; i < MAX_W; i++) begin
      if (i < w) r[i] = q[i-1];
    end
    r[0] = ~q[w-1];
    return r;
  endfunction

  // The 2*w legal codes are exactly the w-bit words with at most one
  // transition between adjacent bits (0..01..1 or 1..10..0).
  function automatic logic johnson_is_legal(input logic [MAX_W-1:0] q, input int w);
    int tr;
    tr = 0;
    for (int i = 0; i < MAX_W - 1; i++) begin
      if ((i < w - 1) && (q[i] != q[i+1])) tr++;
    end
    return (tr <= 1);
  endfunction

  // Phase index: ones-count on the filling half, 2w - ones on the draining half.
  function automatic int johnson_idx(input logic [MAX_W-1:0] q, input int w);
    int ones;
    ones = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if ((i < w) && q[i]) ones++;
    end
    return (q[0] || (ones == 0)) ? ones : (2 * w - ones);
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Purely combinational Johnson code decoder: legality, phase index, one-hot phase.
// onehot is all zeros for an illegal code; idx is meaningless when legal=0.
module johnson_decode
  import johnson_pkg::*;
#(
  parameter  int WIDTH = JOHNSON_W,
  localparam int IW    = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0]   q,
  output logic               legal,
  output logic [IW-1:0]      idx,
  output logic [2*WIDTH-1:0] onehot
);

  logic [MAX_W-1:0] qx;

  // Decode the code into legality, index and one-hot phase.
  always_comb begin
    qx     = MAX_W'(q);
    legal  = johnson_is_legal(qx, WIDTH);
    idx    = IW'(johnson_idx(qx, WIDTH));
    onehot = '0;
    if (legal) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Johnson counter phase monitor: decodes each sample, classifies the step
// against the previous sample, runs the lock FSM and keeps a saturating error
// count. Every output is registered with one cycle of latency.
module johnson_phase_monitor
  import johnson_pkg::*;
#(
  parameter  int WIDTH    = JOHNSON_W,
  parameter  int LOCK_CNT = 4,
  parameter  int ERR_W    = 8,
  localparam int IW       = $clog2(2 * WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   q_in,
  output logic [2*WIDTH-1:0] phase_onehot,
  output logic [IW-1:0]      phase_idx,
  output logic               legal,
  output logic               locked,
  output logic               err_pulse,
  output logic               wrap_pulse,
  output logic [ERR_W-1:0]   err_count
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);

  // ---- stage p0: combinational view of the current sample ----
  logic               legal_p0;
  logic [IW-1:0]      idx_p0;
  logic [2*WIDTH-1:0] onehot_p0;
  logic [WIDTH-1:0]   succ_p0;
  logic               cmp_en_p0, step_p0, hold_p0, bad_p0, err_p0, wrap_p0;

  logic [WIDTH-1:0]   q_prev;
  logic               prev_valid;
  lock_state_t        state, state_nxt;
  logic [RUN_W-1:0]   run, run_nxt, run_inc;

  logic [IW-1:0]      idx_nxt;
  logic [ERR_W-1:0]   cnt_nxt;
  logic               locked_nxt;

  johnson_decode #(.WIDTH(WIDTH)) u_decode (
    .q      (q_in),
    .legal  (legal_p0),
    .idx    (idx_p0),
    .onehot (onehot_p0)
  );

  assign succ_p0 = WIDTH'(johnson_succ(MAX_W'(q_prev), WIDTH));
  assign run_inc = run + 1'b1;

  // Classify the step; comparison only when the previous sample exists and was legal.
  always_comb begin
    cmp_en_p0 = prev_valid & legal;
    step_p0   = cmp_en_p0 & legal_p0 & (q_in == succ_p0);
    hold_p0   = cmp_en_p0 & legal_p0 & (q_in == q_prev);
    bad_p0    = cmp_en_p0 & legal_p0 & ~step_p0 & ~hold_p0;
    err_p0    = prev_valid & (~legal_p0 | bad_p0);
    wrap_p0   = step_p0 & (state == S_LOCK) & (idx_p0 == '0);
  end

  // Lock FSM next state: an error always wins over completing lock.
  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    unique case (state)
      S_UNLOCK: begin
        if (legal_p0) begin
          state_nxt = S_ACQ;
          run_nxt   = '0;
        end
      end
      S_ACQ: begin
        if (!legal_p0 || bad_p0) begin
          state_nxt = S_UNLOCK;
          run_nxt   = '0;
        end else if (step_p0) begin
          run_nxt = run_inc;
          if (run_inc == RUN_W'(LOCK_CNT)) state_nxt = S_LOCK;
        end
      end
      S_LOCK: begin
        if (!legal_p0 || bad_p0) begin
          state_nxt = S_UNLOCK;
          run_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_UNLOCK;
        run_nxt   = '0;
      end
    endcase
  end

  // Output next values: index holds across illegal samples, counter saturates.
  always_comb begin
    locked_nxt = (state_nxt == S_LOCK);
    idx_nxt    = legal_p0 ? idx_p0 : phase_idx;
    cnt_nxt    = err_count;
    if (err_p0 && (err_count != {ERR_W{1'b1}})) cnt_nxt = err_count + 1'b1;
  end

  // ---- stage p1: registered state ----
  // Lock FSM state and run counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_UNLOCK;
      run   <= '0;
    end else begin
      state <= state_nxt;
      run   <= run_nxt;
    end
  end

  // Previous-sample history and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_prev       <= '0;
      prev_valid   <= 1'b0;
      phase_onehot <= '0;
      phase_idx    <= '0;
      legal        <= 1'b0;
      locked       <= 1'b0;
      err_pulse    <= 1'b0;
      wrap_pulse   <= 1'b0;
      err_count    <= '0;
    end else begin
      q_prev       <= q_in;
      prev_valid   <= 1'b1;
      phase_onehot <= onehot_p0;
      phase_idx    <= idx_nxt;
      legal        <= legal_p0;
      locked       <= locked_nxt;
      err_pulse    <= err_p0;
      wrap_pulse   <= wrap_p0;
      err_count    <= cnt_nxt;
    end
  end

endmodule

// File: doc/johnson_phase_monitor.md
Name: johnson_phase_monitor

Overview:
- Downstream consumer of the 4-bit Johnson counter.
- Samples the counter's `q` every clock, decodes it into a one-hot phase and an index, and checks each step against the legal Johnson successor.
- Runs a lock state machine and reports sequence errors and full-cycle wraps.
- Feeds phase-timed logic and status/debug counters.

Parameters:
- WIDTH, 4, Johnson counter width; legal states = 2*WIDTH.
- LOCK_CNT, 4, consecutive correct steps required to declare lock (1..2*WIDTH).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- q_in  in  WIDTH  Johnson counter output.
- phase_onehot  out  2*WIDTH  one-hot decoded phase; all zeros if illegal.
- phase_idx  out  $clog2(2*WIDTH)  index of last legal phase.
- legal  out  1  last sample was a legal Johnson code.
- locked  out  1  lock FSM is in S_LOCK.
- err_pulse  out  1  one-cycle pulse per detected error.
- wrap_pulse  out  1  one-cycle pulse on the phase 2W-1 -> 0 step while locked.
- err_count  out  ERR_W  saturating error count.

Behaviour:
- Interface fixed: single clock `clk`; `reset` is synchronous and active-low.
- Legal sequence, index 0..7 for WIDTH=4: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000.
  - succ(q) = {q[WIDTH-2:0], ~q[WIDTH-1]}.
  - idx = number of ones if q[0]==1 or q==0; otherwise 2*WIDTH - number of ones.
- All outputs are registered, latency 1: values present after edge t reflect q_in sampled at edge t.
- Internal q_prev and prev_valid registers hold the previous sample.
- Step classification, evaluated only when prev_valid=1 and the previous sample was legal:
  - STEP: q_in == succ(q_prev).
  - HOLD: q_in == q_prev.
  - BAD: anything else.
- Illegal sample: legal=0, phase_onehot=0, phase_idx holds, err_pulse=1.
- BAD step of legal codes: err_pulse=1.
- First sample after reset is never an error.
- A legal sample following an illegal one is not a BAD step. It starts a fresh comparison.
- err_count increments on each err_pulse and saturates at 2^ERR_W-1. It never wraps.
- Lock FSM (state and run counter are registered):
  - S_UNLOCK: legal sample -> S_ACQ with run=0.
  - S_ACQ:
    - STEP -> run+1; entering S_LOCK when run+1 == LOCK_CNT.
    - HOLD -> stay, run kept.
    - illegal or BAD -> S_UNLOCK.
  - S_LOCK:
    - STEP or HOLD -> stay.
    - illegal or BAD -> S_UNLOCK. locked drops in the same cycle err_pulse asserts.
- wrap_pulse=1 only for a STEP from idx 2W-1 to idx 0 when the FSM was in S_LOCK before the edge.
- Simultaneous events:
  - An error on the same step that would complete lock -> S_UNLOCK, no lock.
  - wrap_pulse and err_pulse are mutually exclusive by construction.
- Reset (reset==0 at an edge), mid-operation included:
  - FSM=S_UNLOCK, run=0, prev_valid=0, q_prev=0.
  - All outputs 0: phase_onehot, phase_idx, legal, locked, err_pulse, wrap_pulse, err_count.
  - Reset overrides all other events.

Decomposition:
- Package johnson_pkg:
  - lock_state_t enum (S_UNLOCK, S_ACQ, S_LOCK).
  - functions johnson_succ(q), johnson_is_legal(q), johnson_idx(q), all parameterised by WIDTH.
  - IDX_W = $clog2(2*WIDTH).
- One sub-module: johnson_decode. Combinational q -> legal, idx, onehot; reused by other Johnson consumers.
- Lock FSM, step classifier and counters live in the top.

Test Plan:
- Reset behaviour: reset=0 for 2 cycles with q_in=0101 -> all outputs 0 and err_count=0. Release reset, feed 0000 -> legal=1, phase_onehot=00000001, err_pulse=0.
- Acquire lock: feed 0000, 0001, 0011, 0111, 1111 on consecutive edges.
  - 0011 gives phase_onehot=00000100, phase_idx=2.
  - locked=0 through 0111 and becomes 1 after the 1111 sample (4th STEP).
- Wrap: while locked, continue 1110, 1100, 1000, 0000 -> phase_idx 5, 6, 7, 0. wrap_pulse=1 only on the 0000 cycle, err_pulse stays 0.
- Illegal code: while locked at 0011, inject 0101 -> legal=0, phase_onehot=0, phase_idx stays 2, err_pulse=1, err_count=1, locked=0. The next legal 0111 gives no error and enters acquisition.
- BAD and HOLD steps:
  - While locked, 0111 then 0111 -> no error, locked stays 1.
  - Then 1100 (skip) -> err_pulse=1, locked=0.
- Saturation and reset mid-operation:
  - ERR_W=2, inject 5 illegal codes -> err_count 1, 2, 3, 3, 3.
  - Then assert reset while locked -> next edge err_count=0, locked=0, phase_onehot=0.
